// File: rtl/fwd_scoreboard_pkg.sv
// Shared pipeline typedefs: forward-source one-hot and shadow slot record.
// Pure types/helpers, no timing or flow control.
package fwd_scoreboard_pkg;

  typedef struct packed {
    logic ex;
    logic mem0;
    logic mem1;
  } fwd_type_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       late;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // x0 is hardwired zero, so it never produces a forward.
  function automatic logic slot_hit(input slot_t s, input logic [4:0] rs);
    return s.valid && (s.rd != 5'd0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Decode/stage-control inputs and forwarding results of the scoreboard.
// Combinational bundle; no flow control of its own.
interface fwd_scoreboard_if;
  import fwd_scoreboard_pkg::*;

  logic       de_valid;
  logic       de_stall;
  logic [4:0] de_rs1;
  logic [4:0] de_rs2;
  logic [4:0] de_wb_reg;
  logic       de_mem_read;
  logic       ex_stall;
  logic       mem0_stall;
  logic       mem1_stall;
  logic       ex_br_miss;
  logic       csr_kill;
  fwd_type_t  fwd_rs1;
  fwd_type_t  fwd_rs2;
  logic       fwd_stall;
  logic [31:0] fwd_stall_count;

  modport master (
    output de_valid, de_stall, de_rs1, de_rs2, de_wb_reg, de_mem_read,
    output ex_stall, mem0_stall, mem1_stall, ex_br_miss, csr_kill,
    input  fwd_rs1, fwd_rs2, fwd_stall, fwd_stall_count
  );

  modport slave (
    input  de_valid, de_stall, de_rs1, de_rs2, de_wb_reg, de_mem_read,
    input  ex_stall, mem0_stall, mem1_stall, ex_br_miss, csr_kill,
    output fwd_rs1, fwd_rs2, fwd_stall, fwd_stall_count
  );

endinterface

// File: rtl/fwd_match.sv
// One source register against the EX/MEM0/MEM1 slots: youngest-match one-hot plus its late flag.
// Purely combinational; no backpressure.
module fwd_match
  import fwd_scoreboard_pkg::*;
(
  input  logic [4:0] rs,
  input  slot_t      ex_slot,
  input  slot_t      mem0_slot,
  input  slot_t      mem1_slot,
  output fwd_type_t  fwd,
  output logic       late_hit
);

  logic hit_ex;
  logic hit_mem0;
  logic hit_mem1;

  assign hit_ex   = slot_hit(ex_slot, rs);
  assign hit_mem0 = slot_hit(mem0_slot, rs);
  assign hit_mem1 = slot_hit(mem1_slot, rs);

  // Youngest producer wins; late_hit reports the late flag of that producer only.
  always_comb begin
    fwd      = '0;
    late_hit = 1'b0;
    if (hit_ex) begin
      fwd.ex   = 1'b1;
      late_hit = ex_slot.late;
    end else if (hit_mem0) begin
      fwd.mem0 = 1'b1;
      late_hit = mem0_slot.late;
    end else if (hit_mem1) begin
      fwd.mem1 = 1'b1;
      late_hit = mem1_slot.late;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard shadowing EX/MEM0/MEM1; outputs are combinational off slot flops.
// Stalls decode on late results still in EX/MEM0; optional stall counter under FWD_STALL_COUNT_EN.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
(
  input logic             clk_core,
  input logic             reset_n,
  fwd_scoreboard_if.slave sb
);

  slot_t ex_slot, mem0_slot, mem1_slot;
  slot_t ex_nxt, mem0_nxt, mem1_nxt;
  logic  late_rs1, late_rs2;

  always_comb begin
    ex_nxt   = ex_slot;
    mem0_nxt = mem0_slot;
    mem1_nxt = mem1_slot;
    if (!sb.ex_stall) begin
      ex_nxt.valid = sb.de_valid & ~sb.de_stall & ~sb.ex_br_miss;
      ex_nxt.rd    = sb.de_wb_reg;
      ex_nxt.late  = sb.de_mem_read;
    end
    if (!sb.mem0_stall) mem0_nxt = sb.ex_stall ? SLOT_BUBBLE : ex_slot;
    if (!sb.mem1_stall) mem1_nxt = sb.mem0_stall ? SLOT_BUBBLE : mem0_slot;
    // Kill reaches only the younger two stages; MEM1 is already committed.
    if (sb.csr_kill) begin
      ex_nxt.valid   = 1'b0;
      mem0_nxt.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      ex_slot   <= SLOT_BUBBLE;
      mem0_slot <= SLOT_BUBBLE;
      mem1_slot <= SLOT_BUBBLE;
    end else begin
      ex_slot   <= ex_nxt;
      mem0_slot <= mem0_nxt;
      mem1_slot <= mem1_nxt;
    end
  end

  fwd_match u_match_rs1 (
    .rs        (sb.de_rs1),
    .ex_slot   (ex_slot),
    .mem0_slot (mem0_slot),
    .mem1_slot (mem1_slot),
    .fwd       (sb.fwd_rs1),
    .late_hit  (late_rs1)
  );

  fwd_match u_match_rs2 (
    .rs        (sb.de_rs2),
    .ex_slot   (ex_slot),
    .mem0_slot (mem0_slot),
    .mem1_slot (mem1_slot),
    .fwd       (sb.fwd_rs2),
    .late_hit  (late_rs2)
  );

  // Late data is available in MEM1, so a late hit there forwards without stalling.
  assign sb.fwd_stall = sb.de_valid &
                        ((late_rs1 & ~sb.fwd_rs1.mem1) | (late_rs2 & ~sb.fwd_rs2.mem1));

`ifdef FWD_STALL_COUNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (sb.fwd_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign sb.fwd_stall_count = stall_cnt;
`else
  assign sb.fwd_stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and random checks of fwd_scoreboard against an instruction-level pipeline model.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fwd_scoreboard_if sb_if ();

  fwd_scoreboard dut (
    .clk_core (clk),
    .reset_n  (reset_n),
    .sb       (sb_if)
  );

  int checks = 0;
  int errors = 0;

  // Model: pipe[0]=EX, pipe[1]=MEM0, pipe[2]=MEM1, each an in-flight instruction record.
  typedef struct {
    bit valid;
    int rd;
    bit late;
  } instr_t;

  instr_t pipe [3];
  longint model_count;

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) pipe[s] = '{valid: 1'b0, rd: 0, late: 1'b0};
    model_count = 0;
  endfunction

  function automatic int youngest(input int rs);
    for (int s = 0; s < 3; s++)
      if (pipe[s].valid && pipe[s].rd != 0 && pipe[s].rd == rs) return s;
    return -1;
  endfunction

  function automatic logic [2:0] exp_fwd(input int rs);
    int s;
    s = youngest(rs);
    if (s < 0) return 3'b000;
    return 3'b100 >> s;
  endfunction

  function automatic bit stall_for(input int rs);
    int s;
    s = youngest(rs);
    return (s == 0 || s == 1) && pipe[s].late;
  endfunction

  function automatic bit exp_stall();
    return sb_if.de_valid &&
           (stall_for(int'(sb_if.de_rs1)) || stall_for(int'(sb_if.de_rs2)));
  endfunction

  function automatic logic [31:0] exp_count();
`ifdef FWD_STALL_COUNT_EN
    return model_count[31:0];
`else
    return 32'd0;
`endif
  endfunction

  function automatic void model_edge();
    bit     st;
    bit     stg_stall [3];
    instr_t dec;
    instr_t bubble;
    st = exp_stall();
    stg_stall[0] = sb_if.ex_stall;
    stg_stall[1] = sb_if.mem0_stall;
    stg_stall[2] = sb_if.mem1_stall;
    bubble = '{valid: 1'b0, rd: 0, late: 1'b0};
    dec = '{valid: sb_if.de_valid && !sb_if.de_stall && !sb_if.ex_br_miss,
            rd: int'(sb_if.de_wb_reg), late: sb_if.de_mem_read};
    for (int s = 2; s >= 0; s--) begin
      if (!stg_stall[s]) begin
        if (s == 0) pipe[s] = dec;
        else pipe[s] = stg_stall[s-1] ? bubble : pipe[s-1];
      end
    end
    if (sb_if.csr_kill) begin
      pipe[0].valid = 1'b0;
      pipe[1].valid = 1'b0;
    end
    if (st && model_count < 64'hFFFF_FFFF) model_count++;
  endfunction

  task automatic drive(input bit v, input bit ds, input int r1, input int r2, input int wb,
                       input bit ld, input bit es, input bit m0s, input bit m1s,
                       input bit br, input bit kl);
    sb_if.de_valid    = v;
    sb_if.de_stall    = ds;
    sb_if.de_rs1      = r1[4:0];
    sb_if.de_rs2      = r2[4:0];
    sb_if.de_wb_reg   = wb[4:0];
    sb_if.de_mem_read = ld;
    sb_if.ex_stall    = es;
    sb_if.mem0_stall  = m0s;
    sb_if.mem1_stall  = m1s;
    sb_if.ex_br_miss  = br;
    sb_if.csr_kill    = kl;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] got1, got2;
    got1 = sb_if.fwd_rs1;
    got2 = sb_if.fwd_rs2;
    checks++;
    assert (got1 === exp_fwd(int'(sb_if.de_rs1))) else begin
      errors++;
      $error("FAIL %s fwd_rs1 got %b want %b", tag, got1, exp_fwd(int'(sb_if.de_rs1)));
    end
    checks++;
    assert (got2 === exp_fwd(int'(sb_if.de_rs2))) else begin
      errors++;
      $error("FAIL %s fwd_rs2 got %b want %b", tag, got2, exp_fwd(int'(sb_if.de_rs2)));
    end
    checks++;
    assert (sb_if.fwd_stall === exp_stall()) else begin
      errors++;
      $error("FAIL %s fwd_stall got %b want %b", tag, sb_if.fwd_stall, exp_stall());
    end
    checks++;
    assert (sb_if.fwd_stall_count === exp_count()) else begin
      errors++;
      $error("FAIL %s fwd_stall_count got %0d want %0d", tag, sb_if.fwd_stall_count, exp_count());
    end
  endtask

  task automatic check_lit(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    #1;
    check_all(tag);
    tick();
  endtask

  task automatic flush();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    model_reset();
    drive(1, 0, 5, 5, 5, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    step("in_reset");
    step("in_reset_edge");
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_reset");

    // add x5 then a reader of x5: forwarded from EX, no stall
    drive(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    step("add_x5");
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_lit("add_fwd_rs1", 32'(sb_if.fwd_rs1), 32'b100);
    check_lit("add_stall", 32'(sb_if.fwd_stall), 32'd0);
    step("add_use");

    // load-use: two stall cycles, then MEM1 forward
    flush();
    drive(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    step("lw_x7");
    drive(1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_lit("lw_stall_ex", 32'(sb_if.fwd_stall), 32'd1);
    check_lit("lw_fwd_ex", 32'(sb_if.fwd_rs2), 32'b100);
    step("lw_use0");
    #1;
    check_lit("lw_stall_mem0", 32'(sb_if.fwd_stall), 32'd1);
    check_lit("lw_fwd_mem0", 32'(sb_if.fwd_rs2), 32'b010);
    step("lw_use1");
    drive(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_lit("lw_stall_mem1", 32'(sb_if.fwd_stall), 32'd0);
    check_lit("lw_fwd_mem1", 32'(sb_if.fwd_rs2), 32'b001);
    step("lw_use2");

    // younger non-late producer shadows an older load
    flush();
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    step("lw_x3");
    drive(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    step("addi_x3");
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_lit("shadow_fwd", 32'(sb_if.fwd_rs1), 32'b100);
    check_lit("shadow_stall", 32'(sb_if.fwd_stall), 32'd0);
    step("shadow_use");

    // x0 never forwards
    flush();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("wb_x0");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_lit("x0_fwd", 32'(sb_if.fwd_rs1), 32'b000);
    check_lit("x0_stall", 32'(sb_if.fwd_stall), 32'd0);
    step("x0_use");

    // csr_kill removes a load from EX/MEM0
    flush();
    drive(1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    step("lw_x9");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("kill");
    drive(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_lit("kill_fwd", 32'(sb_if.fwd_rs1), 32'b000);
    check_lit("kill_stall", 32'(sb_if.fwd_stall), 32'd0);
    step("kill_use");

    // br_miss and csr_kill together
    flush();
    drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    step("lw_x6");
    drive(1, 0, 0, 0, 8, 0, 0, 0, 0, 1, 1);
    step("miss_kill");
    drive(1, 0, 6, 8, 0, 0, 0, 0, 0, 0, 0);
    step("miss_kill_use");

    // stall counter from reset, then reset mid-stall
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    step("lw_x4");
    drive(1, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (5) step("cnt_stall");
    #1;
`ifdef FWD_STALL_COUNT_EN
    check_lit("cnt_five", sb_if.fwd_stall_count, 32'd5);
`else
    check_lit("cnt_tied", sb_if.fwd_stall_count, 32'd0);
`endif
    check_lit("cnt_still_stall", 32'(sb_if.fwd_stall), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_lit("rst_mid_stall", 32'(sb_if.fwd_stall), 32'd0);
    check_lit("rst_mid_count", sb_if.fwd_stall_count, 32'd0);
    check_all("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic over a small register set to force frequent hits
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have port clk_core, input, 1, core clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port de_valid, input, 1, decode holds a valid instruction.
REQ-004 SHALL have port de_stall, input, 1, decode is holding its instruction this cycle.
REQ-005 SHALL have port de_rs1 / de_rs2, input, 5 each, decode source registers.
REQ-006 SHALL have port de_wb_reg, input, 5, decode destination register (0 = none).
REQ-007 SHALL have port de_mem_read, input, 1, decode instruction is late-result: load or CSR read, data first available in MEM1.
REQ-008 SHALL have ports ex_stall / mem0_stall / mem1_stall, input, 1 each, stage is holding its instruction.
REQ-009 SHALL have port ex_br_miss, input, 1, branch mispredict resolved in EX; decode instruction is wrong-path.
REQ-010 SHALL have port csr_kill, input, 1, pipeline kill from CSR unit.
REQ-011 SHALL have ports fwd_rs1 / fwd_rs2, output, fwd_type_t, one-hot forward source {ex, mem0, mem1}; all-zero = register file.
REQ-012 SHALL have port fwd_stall, output, 1, decode must stall for an unavailable operand.
REQ-013 SHALL have port fwd_stall_count, output, 32, stall-cycle counter (see Configuration).

Function
REQ-014 SHALL hold three shadow slots EX, MEM0, MEM1, each {valid, rd[4:0], late}, mirroring the core pipeline.
REQ-015 EX slot: when ~ex_stall SHALL load {de_valid & ~de_stall & ~ex_br_miss, de_wb_reg, de_mem_read}; when ex_stall SHALL hold.
REQ-016 MEM0 slot: when ~mem0_stall SHALL load EX slot, or a bubble (valid=0) if ex_stall; when mem0_stall SHALL hold.
REQ-017 MEM1 slot: when ~mem1_stall SHALL load MEM0 slot, or a bubble if mem0_stall; when mem1_stall SHALL hold.
REQ-018 csr_kill SHALL clear EX and MEM0 valid at the next edge, overriding REQ-015/016; MEM1 is unaffected.
REQ-019 Slot match for rs SHALL be valid & (rd != 0) & (rd == rs); x0 never matches.
REQ-020 fwd_rsN SHALL be combinational, one-hot on the youngest matching slot, priority EX > MEM0 > MEM1, zero if no match.
REQ-021 fwd_stall SHALL be de_valid & (for rs1 or rs2, the youngest match is a late slot in EX or MEM0); a late match in MEM1 SHALL forward without stall.
REQ-022 An older late match shadowed by a younger non-late match SHALL NOT stall.
REQ-023 Forwarding/stall from a slot SHALL take effect the cycle after that instruction enters EX, i.e. zero added latency beyond the slot registers.
REQ-024 ex_br_miss and csr_kill asserted together SHALL give the union of their effects.

Reset
REQ-025 On reset_n low, all slot valids SHALL clear asynchronously; rd/late values are don't-care.
REQ-026 During and after reset, fwd_rs1 = fwd_rs2 = 0, fwd_stall = 0, fwd_stall_count = 0, until state is loaded.
REQ-027 Reset asserted mid-stall SHALL release the stall in the same cycle.

Configuration
REQ-028 Macro FWD_STALL_COUNT_EN: when defined, fwd_stall_count SHALL increment on each clock with fwd_stall=1, saturating at 32'hFFFFFFFF; csr_kill SHALL not clear it.
REQ-029 When FWD_STALL_COUNT_EN is undefined, fwd_stall_count SHALL be tied to 0 and no counter flops SHALL exist; port list unchanged.

Structure
REQ-030 fwd_type_t (packed {ex, mem0, mem1}) SHALL live in the shared package with the other pipeline typedefs; the slot struct type SHALL be added there too.
REQ-031 A single sub-module fwd_match (combinational, one rs against three slots -> fwd_type_t + late-hit) SHALL be instantiated twice.

Verification
REQ-032 add x5 enters EX; decode reads rs1=x5 -> fwd_rs1={ex}, fwd_stall=0.
REQ-033 lw x7 enters EX; decode rs2=x7 -> fwd_stall=1 two cycles (EX, MEM0); third cycle fwd_rs2={mem1}, fwd_stall=0.
REQ-034 lw x3 in MEM0, addi x3 in EX; decode rs1=x3 -> fwd_rs1={ex}, fwd_stall=0.
REQ-035 Producer with de_wb_reg=0 followed by reader of x0 -> fwd_rs1=0, fwd_stall=0.
REQ-036 lw x9 in EX, csr_kill pulsed -> next cycle EX/MEM0 invalid, decode reading x9 sees fwd_stall=0, fwd_rs1=0.
REQ-037 With FWD_STALL_COUNT_EN, 5 load-use stall cycles from reset -> fwd_stall_count=5; reset_n low mid-stall -> count 0, fwd_stall=0 immediately.
